snake_dir_ctrl: RTL and testbench

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_dir_ctrl.sv | 139 +++++++++++++
 tb/tb_snake_dir_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced button presses into a 2-deep queue of
// direction changes and applies one queued change per game tick.
// Build option: define REVERSE_BLOCK_EN to discard presses that would
// reverse the snake onto itself. When it is undefined, no reverse-detect
// logic is built.
module snake_dir_ctrl #(
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       turned,
  output logic [1:0] q_count,
  output logic       drop
);

  localparam int unsigned DIR_W = 2;
  localparam int unsigned BTN_N = 4;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

  // Button levels, packed as {up, down, left, right}.
  logic [BTN_N-1:0] lvl;
  logic [BTN_N-1:0] prev;
  logic [BTN_N-1:0] ev;

  // Queue storage: fifo0 is the head, fifo1 is the second entry.
  logic [DIR_W-1:0] fifo0;
  logic [DIR_W-1:0] fifo1;

  logic             ev_valid;
  logic [DIR_W-1:0] cand;
  logic [DIR_W-1:0] ref_dir;
  logic             accept;
  logic             pop;

  logic [DIR_W-1:0] dir_n;
  logic [DIR_W-1:0] fifo0_n;
  logic [DIR_W-1:0] fifo1_n;
  logic [1:0]       q_count_n;
  logic             turned_n;
  logic             drop_n;

  assign lvl = {btn_up, btn_down, btn_left, btn_right};
  assign ev  = lvl & ~prev;

  // Edge-detect, arbitrate, filter, and compute the next queue and direction state.
  always_comb begin
    ev_valid  = |ev;
    cand      = DIR_RIGHT;
    ref_dir   = dir;
    accept    = 1'b0;
    pop       = 1'b0;
    dir_n     = dir;
    fifo0_n   = fifo0;
    fifo1_n   = fifo1;
    q_count_n = q_count;
    turned_n  = 1'b0;
    drop_n    = 1'b0;

    // When several buttons rise together, up wins, then down, then left.
    if (ev[3])      cand = DIR_UP;
    else if (ev[2]) cand = DIR_DOWN;
    else if (ev[1]) cand = DIR_LEFT;
    else            cand = DIR_RIGHT;

    // Compare a new press against the newest pending direction, not the current one.
    case (q_count)
      2'd1:    ref_dir = fifo0;
      2'd2:    ref_dir = fifo1;
      default: ref_dir = dir;
    endcase

`ifdef REVERSE_BLOCK_EN
    accept = ev_valid && (cand != ref_dir) &&
             (cand != {ref_dir[1], ~ref_dir[0]});
`else
    accept = ev_valid && (cand != ref_dir);
`endif

    pop = tick && (q_count != 2'd0);

    if (pop) begin
      dir_n    = fifo0;
      turned_n = 1'b1;
      fifo0_n  = fifo1;
      fifo1_n  = 2'b00;
      if (accept) begin
        // A push in the same cycle as a pop keeps the queue depth, so a full queue cannot drop.
        if (q_count == 2'd1) fifo0_n = cand;
        else                 fifo1_n = cand;
      end else begin
        q_count_n = 2'(q_count - 2'd1);
      end
    end else if (accept) begin
      case (q_count)
        2'd0: begin
          fifo0_n   = cand;
          q_count_n = 2'd1;
        end
        2'd1: begin
          fifo1_n   = cand;
          q_count_n = 2'd2;
        end
        default: drop_n = 1'b1;
      endcase
    end
  end

  // Register all state. Reset sets the previous-level bits to 1 so that buttons held through reset stay silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= {BTN_N{1'b1}};
      dir     <= INIT_DIR;
      fifo0   <= 2'b00;
      fifo1   <= 2'b00;
      q_count <= 2'd0;
      turned  <= 1'b0;
      drop    <= 1'b0;
    end else begin
      prev    <= lvl;
      dir     <= dir_n;
      fifo0   <= fifo0_n;
      fifo1   <= fifo1_n;
      q_count <= q_count_n;
      turned  <= turned_n;
      drop    <= drop_n;
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Testbench for snake_dir_ctrl: runs directed scenarios, then random
// stimulus. Each cycle is checked against a queue-based behavioural model.
module tb_snake_dir_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       tick;
  logic [1:0] dir;
  logic       turned;
  logic [1:0] q_count;
  logic       drop;

  int n_cmp;
  int n_err;

  // Behavioural model state. Button index i corresponds to direction code i.
  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  logic       m_prev[4];
  logic       m_turned;
  logic       m_drop;

  snake_dir_ctrl #(.INIT_DIR(2'b11)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .tick      (tick),
    .dir       (dir),
    .turned    (turned),
    .q_count   (q_count),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge, based on the spec rules.
  task automatic model_step(input logic r, input logic [3:0] lv, input logic tk);
    int        found;
    logic [1:0] refd;
    logic       acc;
    if (r) begin
      m_dir = 2'b11;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_prev[i] = 1'b1;
      m_turned = 1'b0;
      m_drop   = 1'b0;
    end else begin
      found = -1;
      for (int i = 0; i < 4; i++)
        if (found < 0 && lv[i] && !m_prev[i]) found = i;
      refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
      acc  = (found >= 0) && (2'(found) != refd);
`ifdef REVERSE_BLOCK_EN
      acc  = acc && (2'(found) != (refd ^ 2'b01));
`endif
      m_drop   = 1'b0;
      m_turned = tk && (m_q.size() > 0);
      if (m_turned) m_dir = m_q.pop_front();
      if (acc) begin
        if (m_q.size() < 2) m_q.push_back(2'(found));
        else                m_drop = 1'b1;
      end
      for (int i = 0; i < 4; i++) m_prev[i] = lv[i];
    end
  endtask

  // Drive one cycle of inputs, update the model, and check the outputs after the edge.
  task automatic cycle(input logic r, input logic [3:0] lv, input logic tk);
    @(negedge clk);
    rst       = r;
    btn_up    = lv[0];
    btn_down  = lv[1];
    btn_left  = lv[2];
    btn_right = lv[3];
    tick      = tk;
    model_step(r, lv, tk);
    @(posedge clk);
    #1;
    check_eq("dir",     32'(dir),     32'(m_dir));
    check_eq("turned",  32'(turned),  32'(m_turned));
    check_eq("q_count", 32'(q_count), 32'(m_q.size()));
    check_eq("drop",    32'(drop),    32'(m_drop));
  endtask

  // Directed scenarios first, then random stimulus.
  initial begin
    logic [3:0] lv;
    logic       r;
    logic       tk;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    btn_right = 1'b0; tick = 1'b0;

    // Right is held through reset and produces no event until it is re-pressed.
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Press up, then tick: the snake turns up.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // Press up, then left, then down: down is either filtered or dropped.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0010, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    // With a full queue, a press and a tick in the same cycle must not drop.
    cycle(1'b0, 4'b0010, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Up and left rise together: only up is queued.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0101, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);

    // Press right (equal to dir), then left (its reverse), then tick.
    cycle(1'b1, 4'b0000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);

    // Random stimulus with sparse toggles, ticks, and occasional resets.
    lv = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) lv[i] = ~lv[i];
      tk = ($urandom_range(3) == 0);
      r  = ($urandom_range(99) == 0);
      cycle(r, lv, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
